// File: rtl/deserializer.sv
// rtl/deserializer.sv - 1-bit stream to DATA_WIDTH-bit word deserializer with valid/ready output.
// Optional saturating error counter built when DESER_ERR_COUNT_EN is defined.
module deserializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  serial_in_i,
  input  logic                  enable_i,
  input  logic                  start_i,
  output logic [DATA_WIDTH-1:0] parallel_out_o,
  output logic                  valid_out_o,
  input  logic                  ready_i,
  output logic                  frame_err_o,
  output logic                  overflow_o,
  output logic [7:0]            err_count_o
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic {IDLE, RECV} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CW-1:0]         bit_cnt;
  logic                  last_bit;
  logic                  handshake;

  assign last_bit  = (state == RECV) && enable_i && !start_i &&
                     (bit_cnt == CW'(DATA_WIDTH - 1));
  assign handshake = valid_out_o && ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= IDLE;
      shift_reg      <= '0;
      bit_cnt        <= '0;
      parallel_out_o <= '0;
      valid_out_o    <= 1'b0;
      frame_err_o    <= 1'b0;
      overflow_o     <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
      // A completing word below overrides this clear.
      if (handshake) valid_out_o <= 1'b0;
      if (enable_i) begin
        if (start_i) begin
          // A start seen while still receiving aborts the partial word.
          frame_err_o <= (state == RECV);
          shift_reg   <= {{(DATA_WIDTH-1){1'b0}}, serial_in_i};
          bit_cnt     <= CW'(1);
          state       <= RECV;
        end else if (state == RECV) begin
          if (last_bit) begin
            parallel_out_o <= {shift_reg[DATA_WIDTH-2:0], serial_in_i};
            valid_out_o    <= 1'b1;
            overflow_o     <= valid_out_o && !ready_i;
            bit_cnt        <= '0;
            state          <= IDLE;
          end else begin
            shift_reg <= {shift_reg[DATA_WIDTH-2:0], serial_in_i};
            bit_cnt   <= bit_cnt + 1'b1;
          end
        end
      end
    end
  end

`ifdef DESER_ERR_COUNT_EN
  logic [8:0] err_sum;

  assign err_sum = {1'b0, err_count_o} + {8'b0, frame_err_o} + {8'b0, overflow_o};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) err_count_o <= '0;
    else          err_count_o <= err_sum[8] ? 8'hFF : err_sum[7:0];
  end
`else
  assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - randomized and directed bench for deserializer against a queue-based model.
module tb_deserializer;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          serial;
  logic          enable;
  logic          start;
  logic          ready;
  logic [DW-1:0] parallel_out;
  logic          valid_out;
  logic          frame_err;
  logic          overflow;
  logic [7:0]    err_count;

  int checks = 0;
  int errors = 0;

  // Reference model: collected bits of the word in flight, plus expected outputs.
  bit          m_bits[$];
  bit          m_collecting;
  logic [DW-1:0] m_data;
  bit          m_valid;
  bit          m_frame;
  bit          m_over;
  int          m_err;
  int          over_pulses;
  int          frame_pulses;

  deserializer #(.DATA_WIDTH(DW)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .serial_in_i    (serial),
    .enable_i       (enable),
    .start_i        (start),
    .parallel_out_o (parallel_out),
    .valid_out_o    (valid_out),
    .ready_i        (ready),
    .frame_err_o    (frame_err),
    .overflow_o     (overflow),
    .err_count_o    (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_collecting = 0;
    m_data = '0;
    m_valid = 0;
    m_frame = 0;
    m_over = 0;
    m_err = 0;
  endtask

  task automatic model_update();
    bit done;
    int sum;
    logic [DW-1:0] word;
    done = 0;
`ifdef DESER_ERR_COUNT_EN
    sum = m_err + int'(m_frame) + int'(m_over);
    m_err = (sum > 255) ? 255 : sum;
`endif
    m_frame = 0;
    m_over = 0;
    if (enable) begin
      if (start) begin
        if (m_collecting) m_frame = 1;
        m_bits.delete();
        m_bits.push_back(serial);
        m_collecting = 1;
      end else if (m_collecting) begin
        m_bits.push_back(serial);
        if (m_bits.size() == DW) begin
          word = '0;
          foreach (m_bits[i]) word[DW-1-i] = m_bits[i];
          m_over = m_valid && !ready;
          m_valid = 1;
          m_data = word;
          done = 1;
          m_collecting = 0;
          m_bits.delete();
        end
      end
    end
    if (!done && m_valid && ready) m_valid = 0;
  endtask

  task automatic compare_all();
    check("valid", valid_out, m_valid);
    if (m_valid) check("data", parallel_out, m_data);
    check("frame_err", frame_err, m_frame);
    check("overflow", overflow, m_over);
    check("err_count", err_count, m_err);
    if (overflow) over_pulses++;
    if (frame_err) frame_pulses++;
  endtask

  task automatic step(input bit s, input bit en, input bit st, input bit rd);
    serial = s;
    enable = en;
    start  = st;
    ready  = rd;
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic send_word(input logic [DW-1:0] w, input bit rd, input int stall_after, input int stall_len);
    for (int i = 0; i < DW; i++) begin
      step(w[DW-1-i], 1'b1, i == 0, rd);
      if (i == stall_after) repeat (stall_len) step(1'b0, 1'b0, 1'b0, rd);
    end
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_data", parallel_out, '0);
    check("rst_valid", valid_out, 1'b0);
    check("rst_frame", frame_err, 1'b0);
    check("rst_over", overflow, 1'b0);
    check("rst_errcnt", err_count, 8'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] w;
    rst_n = 1'b0;
    serial = 0; enable = 0; start = 0; ready = 0;
    model_reset();
    over_pulses = 0;
    frame_pulses = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", valid_out, 1'b0);
    check("reset_data", parallel_out, '0);
    check("reset_errcnt", err_count, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word
    send_word(8'hA5, 1'b1, -1, 0);
    check("a5_data", parallel_out, 8'hA5);
    check("a5_valid", valid_out, 1'b1);
    step(0, 0, 0, 1);
    check("a5_valid_drop", valid_out, 1'b0);

    // Back-to-back, zero gap
    send_word(8'h3C, 1'b1, -1, 0);
    check("b2b_first", parallel_out, 8'h3C);
    send_word(8'hFF, 1'b1, -1, 0);
    check("b2b_second", parallel_out, 8'hFF);
    step(0, 0, 0, 1);

    // Stall after bit 4
    send_word(8'h81, 1'b1, 3, 3);
    check("stall_data", parallel_out, 8'h81);
    step(0, 0, 0, 1);

    // Framing error
    frame_pulses = 0;
    for (int i = 0; i < 4; i++) step(i < 4, 1'b1, i == 0, 1'b1);
    send_word(8'h5A, 1'b1, -1, 0);
    check("frame_data", parallel_out, 8'h5A);
    step(0, 0, 0, 1);
    check("frame_pulses", frame_pulses, 1);

    // Overflow
    over_pulses = 0;
    send_word(8'h11, 1'b0, -1, 0);
    send_word(8'h22, 1'b0, -1, 0);
    step(0, 0, 0, 0);
    check("ovf_pulses", over_pulses, 1);
    check("ovf_data", parallel_out, 8'h22);
    step(0, 0, 0, 1);
    check("ovf_drained", valid_out, 1'b0);

    // Async reset mid-word
    w = 8'hC3;
    for (int i = 0; i < 5; i++) step(w[DW-1-i], 1'b1, i == 0, 1'b1);
    async_reset();

`ifdef DESER_ERR_COUNT_EN
    for (int i = 0; i < 301; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("errcnt_sat", err_count, 8'd255);
    async_reset();
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit en;
      en = ($urandom_range(0, 9) < 7);
      step(1'($urandom), en, en && ($urandom_range(0, 15) == 0), 1'($urandom));
      if (i == 1500) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
